// File: rtl/complex_fir_pipe.sv
`default_nettype none
// ============================================================================
// Module   : complex_fir_pipe
// Purpose  : Parametrised complex FIR filter. It takes valid-qualified I/Q
//            samples, accumulates at full precision, then rounds, shifts and
//            saturates the result. The coefficient bank is double-buffered:
//            writes land in a shadow bank, and a commit copies the whole
//            shadow bank to the active bank in one step. Conjugate
//            coefficient mode is optional, and a sticky flag records
//            output saturation.
// Ports    : clock, reset       - clock; asynchronous active-high reset
//            in_valid/in_I/in_Q - input sample strobe and signed I/Q sample
//            coef_we/coef_addr/coef_I/coef_Q - shadow coefficient write
//            coef_commit        - copy the shadow bank to the active bank
//            sat_clear          - clear the sticky saturation flag
//            out_valid/out_I/out_Q - output strobe and signed I/Q result
//            sat_flag           - sticky: some output was clipped
// Revision : 1.0 - initial release
// ============================================================================
module complex_fir_pipe #(
    parameter int DATA_W      = 12,
    parameter int COEF_W      = 12,
    parameter int TAPS        = 8,
    parameter int OUT_SHIFT   = 11,
    parameter int B_CONJUGATE = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_I,
    input  logic [DATA_W-1:0]       in_Q,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]       coef_I,
    input  logic [COEF_W-1:0]       coef_Q,
    input  logic                    coef_commit,
    input  logic                    sat_clear,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_I,
    output logic [DATA_W-1:0]       out_Q,
    output logic                    sat_flag
);

    localparam int AW      = $clog2(TAPS);
    // A complex product term is the sum of two real products, so it needs
    // one bit above the real product width.
    localparam int PROD_W  = DATA_W + COEF_W + 1;
    // Headroom for summing TAPS products without overflow.
    localparam int ACC_W   = PROD_W + $clog2(TAPS);
    // One more bit so that adding the rounding bias cannot wrap.
    localparam int RND_W   = ACC_W + 1;
    localparam int RND_EXP = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [RND_W-1:0] RND_BIAS =
        (OUT_SHIFT > 0) ? (RND_W'(1) << RND_EXP) : '0;
    localparam logic signed [RND_W-1:0] SAT_MAX =
        (RND_W'(1) << (DATA_W - 1)) - RND_W'(1);
    localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;

    // ------------------------------------------------------------------
    // Coefficient banks
    // ------------------------------------------------------------------
    logic signed [COEF_W-1:0] shd_re_q [TAPS];
    logic signed [COEF_W-1:0] shd_im_q [TAPS];
    logic signed [COEF_W-1:0] act_re_q [TAPS];
    logic signed [COEF_W-1:0] act_im_q [TAPS];

    // The commit reads the shadow bank before any same-cycle write updates
    // it. As a result, a write that coincides with a commit stays in the
    // shadow bank only.
    always_ff @(posedge clock or posedge reset) begin : p_coef
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                shd_re_q[k] <= '0;
                shd_im_q[k] <= '0;
                act_re_q[k] <= '0;
                act_im_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (coef_commit) begin
                    act_re_q[k] <= shd_re_q[k];
                    act_im_q[k] <= shd_im_q[k];
                end
                if (coef_we && (coef_addr == AW'(k))) begin
                    shd_re_q[k] <= $signed(coef_I);
                    shd_im_q[k] <= $signed(coef_Q);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: products of the incoming sample with every active tap
    // ------------------------------------------------------------------
    logic signed [PROD_W-1:0] w_x_re;
    logic signed [PROD_W-1:0] w_x_im;
    logic signed [PROD_W-1:0] prod_re_d [TAPS];
    logic signed [PROD_W-1:0] prod_im_d [TAPS];

    always_comb begin : p_products
        w_x_re = PROD_W'($signed(in_I));
        w_x_im = PROD_W'($signed(in_Q));
        for (int k = 0; k < TAPS; k++) begin
            if (B_CONJUGATE != 0) begin
                prod_re_d[k] = w_x_re * PROD_W'(act_re_q[k])
                             + w_x_im * PROD_W'(act_im_q[k]);
                prod_im_d[k] = w_x_im * PROD_W'(act_re_q[k])
                             - w_x_re * PROD_W'(act_im_q[k]);
            end else begin
                prod_re_d[k] = w_x_re * PROD_W'(act_re_q[k])
                             - w_x_im * PROD_W'(act_im_q[k]);
                prod_im_d[k] = w_x_im * PROD_W'(act_re_q[k])
                             + w_x_re * PROD_W'(act_im_q[k]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 / stage 2 registers.
    // The filter uses the transposed form: sum[k] holds the partial sum
    // that will become part of an output k valid samples from now. The
    // chain moves only on a valid product, so idle cycles are invisible.
    // ------------------------------------------------------------------
    logic                     v1_q;
    logic                     v2_q;
    logic signed [PROD_W-1:0] prod_re_q [TAPS];
    logic signed [PROD_W-1:0] prod_im_q [TAPS];
    logic signed [ACC_W-1:0]  sum_re_q  [TAPS];
    logic signed [ACC_W-1:0]  sum_im_q  [TAPS];

    always_ff @(posedge clock or posedge reset) begin : p_pipe
        if (reset) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                prod_re_q[k] <= '0;
                prod_im_q[k] <= '0;
                sum_re_q[k]  <= '0;
                sum_im_q[k]  <= '0;
            end
        end else begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            if (in_valid) begin
                for (int k = 0; k < TAPS; k++) begin
                    prod_re_q[k] <= prod_re_d[k];
                    prod_im_q[k] <= prod_im_d[k];
                end
            end
            if (v1_q) begin
                for (int k = 0; k < TAPS - 1; k++) begin
                    sum_re_q[k] <= ACC_W'(prod_re_q[k]) + sum_re_q[k+1];
                    sum_im_q[k] <= ACC_W'(prod_im_q[k]) + sum_im_q[k+1];
                end
                sum_re_q[TAPS-1] <= ACC_W'(prod_re_q[TAPS-1]);
                sum_im_q[TAPS-1] <= ACC_W'(prod_im_q[TAPS-1]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: round half up, arithmetic shift, saturate.
    // The returned MSB flags a clip; the low DATA_W bits are the result.
    // ------------------------------------------------------------------
    function automatic logic [DATA_W:0] f_round_sat(
        input logic signed [ACC_W-1:0] acc
    );
        logic signed [RND_W-1:0] v;
        logic        [DATA_W:0]  r;
        v = (RND_W'(acc) + RND_BIAS) >>> OUT_SHIFT;
        if (v > SAT_MAX) begin
            r = {1'b1, SAT_MAX[DATA_W-1:0]};
        end else if (v < SAT_MIN) begin
            r = {1'b1, SAT_MIN[DATA_W-1:0]};
        end else begin
            r = {1'b0, v[DATA_W-1:0]};
        end
        return r;
    endfunction

    logic [DATA_W:0]   w_rs_re;
    logic [DATA_W:0]   w_rs_im;
    logic              sat_flag_d;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_I_q;
    logic [DATA_W-1:0] out_Q_q;
    logic              sat_flag_q;

    assign w_rs_re = f_round_sat(sum_re_q[0]);
    assign w_rs_im = f_round_sat(sum_im_q[0]);

    // A new clip wins over a same-cycle clear, so no clip event is lost.
    always_comb begin : p_sat_next
        sat_flag_d = (sat_flag_q & ~sat_clear)
                   | (v2_q & (w_rs_re[DATA_W] | w_rs_im[DATA_W]));
    end

    always_ff @(posedge clock or posedge reset) begin : p_out
        if (reset) begin
            out_valid_q <= 1'b0;
            out_I_q     <= '0;
            out_Q_q     <= '0;
            sat_flag_q  <= 1'b0;
        end else begin
            out_valid_q <= v2_q;
            sat_flag_q  <= sat_flag_d;
            if (v2_q) begin
                out_I_q <= w_rs_re[DATA_W-1:0];
                out_Q_q <= w_rs_im[DATA_W-1:0];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_I     = out_I_q;
    assign out_Q     = out_Q_q;
    assign sat_flag  = sat_flag_q;

endmodule
`default_nettype wire

// File: doc/complex_fir_pipe.md
Name: complex_fir_pipe

Overview:
- Parametrised complex FIR with valid-qualified input samples, full-precision accumulation, and output round/shift/saturate.
- Double-buffered coefficient bank: shadow writes, atomic commit.
- Optional conjugate coefficient mode; sticky saturation flag.
- Sits in the ANC datapath between the I/Q front end and the adaptive canceller; replaces the fixed-width single-enable FIR.

Parameters:
- DATA_W, 12, width of signed input and output I/Q samples.
- COEF_W, 12, width of signed coefficient I/Q.
- TAPS, 8, number of complex taps (>=2).
- OUT_SHIFT, 11, arithmetic right shift applied to the accumulator before saturation.
- B_CONJUGATE, 1, 1: y = x*conj(c); 0: y = x*c.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample strobe; one sample per high cycle.
- in_I  in  DATA_W  signed input, real part.
- in_Q  in  DATA_W  signed input, imaginary part.
- coef_we  in  1  write one shadow coefficient.
- coef_addr  in  $clog2(TAPS)  tap index k of the write.
- coef_I  in  COEF_W  signed shadow coefficient, real part.
- coef_Q  in  COEF_W  signed shadow coefficient, imaginary part.
- coef_commit  in  1  copy shadow bank to active bank.
- sat_clear  in  1  clear sat_flag.
- out_valid  out  1  output strobe.
- out_I  out  DATA_W  filtered output, real part.
- out_Q  out  DATA_W  filtered output, imaginary part.
- sat_flag  out  1  sticky: an output saturated.

Behaviour:
- Reset (async, high): delay line, product registers, shadow and active banks, out_I, out_Q, out_valid and sat_flag all go to 0.
- Transfer function: y[n] = sum over k=0..TAPS-1 of c[k]*x[n-k]. k=0 is the newest sample. n counts valid samples only.
- Invalid cycles: the delay line holds. Gaps in in_valid do not change results.
- Products:
  - Conj mode: re = xI*cI + xQ*cQ, im = xQ*cI - xI*cQ.
  - Non-conj mode: re = xI*cI - xQ*cQ, im = xQ*cI + xI*cQ.
  - Product width is DATA_W+COEF_W+1; products do not wrap.
- Accumulator width ACC_W = DATA_W+COEF_W+1+$clog2(TAPS); the accumulator never overflows.
- Output stage:
  - v = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, i.e. round half up; no rounding term when OUT_SHIFT=0.
  - v is then saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], independently for I and Q.
- Pipeline and latency:
  - Edge 1: products formed from the registered active bank.
  - Edge 2: transposed delay-line update.
  - Edge 3: rounded and saturated output registered.
  - out_valid is high for exactly 1 cycle, 3 cycles after each in_valid. Back-to-back in_valid gives back-to-back out_valid.
- Outputs hold their values between out_valid pulses.
- Coefficients:
  - coef_we writes shadow[coef_addr] in 1 cycle; the active bank is unaffected.
  - coef_commit copies all TAPS shadow entries to active on that edge.
  - A sample with in_valid in the same cycle as coef_commit uses the old bank. The next valid sample uses the new bank.
  - coef_we and coef_commit in the same cycle: the commit copies the pre-write shadow. The write lands in shadow only.
  - Samples already in the delay line keep their partial sums; there is no flush on commit.
- sat_flag:
  - Set on any out_valid cycle where I or Q clipped.
  - Cleared by sat_clear.
  - sat_clear and a new saturation in the same cycle: the flag stays set.
- Reset mid-stream: all in-flight samples are discarded, and out_valid stays low until 3 cycles after the first valid sample after reset.

Test Plan (DATA_W=12, COEF_W=12, TAPS=4, OUT_SHIFT=11, B_CONJUGATE=1):
- Impulse response:
  - Stimulus: load c=(1024,0),(512,0),(0,1024),(-1024,0) then commit; input (1000,0) followed by 3 zeros.
  - Required: outputs (500,0), (250,0), (0,-500), (-500,0); first out_valid 3 cycles after the impulse.
- Gapped input:
  - Stimulus: repeat the impulse test with 2 idle cycles between samples.
  - Required: identical output values; each out_valid lags its in_valid by exactly 3 cycles.
- Saturation:
  - Stimulus: all coefs (2047,0); input (2047,2047) held for 4 samples.
  - Required: out clamps to (2047,2047); sat_flag=1 until sat_clear; sat_clear in a cycle that saturates again leaves the flag at 1.
- Commit timing:
  - Stimulus: write shadow c0=(2048-1,0) without commit, then send sample (1000,0).
  - Required: output uses the old bank.
  - Stimulus: commit coincident with in_valid.
  - Required: that sample uses the old bank; the next sample uses the new one.
- Non-conj mode (B_CONJUGATE=0):
  - Stimulus: c0=(0,1024), input (1000,0).
  - Required: output (0,500).
- Reset mid-stream:
  - Stimulus: assert reset during a burst.
  - Required: all outputs and sat_flag go to 0 immediately; after release, the first output depends only on post-reset samples.
